// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg
//  Description : Shared types and constants for the data-memory arbiter.
//                State encoding and requester indices are also used by the
//                processor state machine.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Requester indices: port 0 is instruction fetch, port 1 is operand/store
    localparam logic c_req_fetch = 1'b0;
    localparam logic c_req_data  = 1'b1;

    // Supported read-latency range and the counter that walks it
    localparam int c_max_mem_lat = 4;
    localparam int c_lat_cnt_w   = 2;

    // One-hot acknowledge vector {ack1, ack0} for a given owner index
    function automatic logic [1:0] ack_onehot(input logic owner);
        return (owner == c_req_data) ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_arb_rr2.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_arb_rr2
//  Description : Combinational two-way round-robin picker. A lone request
//                wins outright; on a tie the requester that did not win last
//                time is chosen.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter_arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    // Pick a winner from the two request lines and the previous owner
    always_comb begin
        valid  = req0 | req1;
        winner = c_req_fetch;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req1) begin
            winner = c_req_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester arbiter and sequencer for the single-port data
//                memory. Serves one transaction at a time, drives the memory
//                port and returns read data with a one-cycle ack pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              gnt,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Refuse to build with a latency the wait counter cannot represent
    generate
        if ((MEM_LAT < 1) || (MEM_LAT > c_max_mem_lat)) begin : g_bad_mem_lat
            $error("mem_arbiter: MEM_LAT must be within 1..%0d", c_max_mem_lat);
        end
    endgenerate

    // Counter start value so that WAIT lasts exactly MEM_LAT cycles
    localparam logic [c_lat_cnt_w-1:0] c_lat_init = c_lat_cnt_w'(MEM_LAT - 1);

    arb_state_t               r_state;
    logic                     r_last_grant;
    logic                     r_we;
    logic [c_lat_cnt_w-1:0]   r_lat_cnt;

    logic                     w_valid;
    logic                     w_winner;
    logic                     w_sel_we;
    logic [ADDR_W-1:0]        w_sel_addr;
    logic [DATA_W-1:0]        w_sel_wdata;

    mem_arbiter_arb_rr2 u_arb_rr2 (
        .req0       (req0),
        .req1       (req1),
        .last_grant (r_last_grant),
        .valid      (w_valid),
        .winner     (w_winner)
    );

    // Route the winning requester's fields toward the grant latches
    always_comb begin
        w_sel_we    = we0;
        w_sel_addr  = addr0;
        w_sel_wdata = wdata0;
        if (w_winner == c_req_data) begin
            w_sel_we    = we1;
            w_sel_addr  = addr1;
            w_sel_wdata = wdata1;
        end
    end

    // Sequencer: arbitrate, issue, wait for read data, acknowledge.
    // mem_addr/mem_wdata double as the address/data latches: they are only
    // loaded at grant time and otherwise hold their last value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= c_req_data;
            r_we         <= 1'b0;
            r_lat_cnt    <= '0;
            gnt          <= c_req_fetch;
            busy         <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata        <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_we         <= w_sel_we;
                        r_last_grant <= w_winner;
                        gnt          <= w_winner;
                        busy         <= 1'b1;
                        mem_en       <= 1'b1;
                        mem_we       <= w_sel_we;
                        mem_addr     <= w_sel_addr;
                        mem_wdata    <= w_sel_wdata;
                        r_state      <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (r_we) begin
                        {ack1, ack0} <= ack_onehot(gnt);
                        r_state      <= ST_RESP;
                    end else begin
                        r_lat_cnt <= c_lat_init;
                        r_state   <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (r_lat_cnt == '0) begin
                        rdata        <= mem_rdata;
                        {ack1, ack0} <= ack_onehot(gnt);
                        r_state      <= ST_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end

                ST_RESP: begin
                    // Requests are not looked at here; a held req is
                    // re-arbitrated from IDLE as a fresh transaction
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. Two instances (read
//                latency 1 and 3) share the same stimulus; each has its own
//                memory model and transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        req   [2][2];
    logic        we    [2][2];
    logic [15:0] addr  [2][2];
    logic [15:0] wdata [2][2];
    logic        ack   [2][2];

    logic [15:0] rdata     [2];
    logic        gnt       [2];
    logic        busy      [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [15:0] mem_addr  [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_rdata [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(1)) u_dut0 (
        .clk(clk), .reset(reset),
        .req0(req[0][0]), .req1(req[0][1]), .we0(we[0][0]), .we1(we[0][1]),
        .addr0(addr[0][0]), .addr1(addr[0][1]),
        .wdata0(wdata[0][0]), .wdata1(wdata[0][1]),
        .ack0(ack[0][0]), .ack1(ack[0][1]), .rdata(rdata[0]), .gnt(gnt[0]),
        .busy(busy[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    mem_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(3)) u_dut1 (
        .clk(clk), .reset(reset),
        .req0(req[1][0]), .req1(req[1][1]), .we0(we[1][0]), .we1(we[1][1]),
        .addr0(addr[1][0]), .addr1(addr[1][1]),
        .wdata0(wdata[1][0]), .wdata1(wdata[1][1]),
        .ack0(ack[1][0]), .ack1(ack[1][1]), .rdata(rdata[1]), .gnt(gnt[1]),
        .busy(busy[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // ------------------------------------------------------------------
    // Memory macro model: read data appears for exactly one cycle, MEM_LAT
    // edges after mem_en is sampled; junk is presented at all other times.
    // ------------------------------------------------------------------
    logic [15:0] dmem [2][256];
    logic [15:0] pipe [2][4];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            pipe[i][0] <= (mem_en[i] && !mem_we[i]) ? dmem[i][mem_addr[i][7:0]]
                                                    : 16'($urandom);
            for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
            if (mem_en[i] && mem_we[i]) dmem[i][mem_addr[i][7:0]] <= mem_wdata[i];
        end
    end

    assign mem_rdata[0] = pipe[0][0];
    assign mem_rdata[1] = pipe[1][2];

    // ------------------------------------------------------------------
    // Reference model: a transaction occupies cycles 1..D after the grant
    // edge (D = 2 for a write, MEM_LAT+2 for a read); cycle 1 drives the
    // memory, cycle D acks, and one idle cycle follows before the next grant.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        busy;
        logic [3:0]  cyc;
        logic        owner;
        logic        we;
        logic        last;
        logic        gnt;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } mdl_t;

    mdl_t        m    [2];
    logic [15:0] rmem [2][256];

    function automatic logic [3:0] dur(input mdl_t s, input int i);
        return s.we ? 4'd2 : 4'(lat_of(i) + 2);
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s      = '0;
        s.last = 1'b1;
        return s;
    endfunction

    function automatic mdl_t step(input mdl_t s, input int i);
        mdl_t n;
        logic w;
        n = s;
        if (s.busy) begin
            if (s.cyc == dur(s, i)) begin
                n.busy = 1'b0;
            end else begin
                n.cyc = s.cyc + 4'd1;
                if (n.cyc == dur(s, i) && !s.we) n.rdata = rmem[i][s.addr[7:0]];
            end
        end else if (req[i][0] || req[i][1]) begin
            if (req[i][0] && req[i][1]) w = !s.last;
            else                        w = req[i][1];
            n.busy  = 1'b1;
            n.cyc   = 4'd1;
            n.owner = w;
            n.gnt   = w;
            n.last  = w;
            n.we    = we[i][w];
            n.addr  = addr[i][w];
            n.wdata = wdata[i][w];
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) m[i] <= mdl_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                m[i] <= step(m[i], i);
                if (m[i].busy && m[i].cyc == 4'd1 && m[i].we)
                    rmem[i][m[i].addr[7:0]] <= m[i].wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers (all called from the single main process)
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %h, expected %h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output to the model
    task automatic tick();
        logic e_en, e_a0, e_a1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            e_en = m[i].busy && (m[i].cyc == 4'd1);
            e_a0 = m[i].busy && (m[i].cyc == dur(m[i], i)) && (m[i].owner == 1'b0);
            e_a1 = m[i].busy && (m[i].cyc == dur(m[i], i)) && (m[i].owner == 1'b1);
            chk("busy",   i, 32'(busy[i]),   32'(m[i].busy));
            chk("gnt",    i, 32'(gnt[i]),    32'(m[i].gnt));
            chk("ack0",   i, 32'(ack[i][0]), 32'(e_a0));
            chk("ack1",   i, 32'(ack[i][1]), 32'(e_a1));
            chk("mem_en", i, 32'(mem_en[i]), 32'(e_en));
            chk("mem_we", i, 32'(mem_we[i]), 32'(e_en && m[i].we));
            chk("rdata",  i, 32'(rdata[i]),  32'(m[i].rdata));
            // Address/data registers hold the last granted request's fields
            chk("mem_addr",  i, 32'(mem_addr[i]),  32'(m[i].addr));
            chk("mem_wdata", i, 32'(mem_wdata[i]), 32'(m[i].wdata));
        end
    endtask

    task automatic set_req(input int i, input int r, input logic v, input logic w,
                           input logic [15:0] a, input logic [15:0] d);
        req[i][r]   = v;
        we[i][r]    = w;
        addr[i][r]  = a;
        wdata[i][r] = d;
    endtask

    // Reset pulse asserted and released between clock edges
    task automatic reset_pulse();
        #2 reset = 1'b0;
        tick();
        #2 reset = 1'b1;
    endtask

    // One isolated transaction on requester r, applied to both instances
    task automatic single(input int r, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input int exp_ack0, input int exp_ack1,
                          input logic [15:0] exp_rd);
        int ackat [2];
        int nen   [2];
        int nbusy [2];
        for (int i = 0; i < 2; i++) begin
            ackat[i] = 0; nen[i] = 0; nbusy[i] = 0;
            set_req(i, r, 1'b1, w, a, d);
        end
        for (int c = 1; c <= 12; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (busy[i]) nbusy[i]++;
                if (mem_en[i]) begin
                    nen[i]++;
                    chk("issue_addr", i, 32'(mem_addr[i]), 32'(a));
                    chk("issue_we",   i, 32'(mem_we[i]),   32'(w));
                end
                if (ack[i][r] && ackat[i] == 0) begin
                    ackat[i] = c;
                    chk("ack_rdata", i, 32'(rdata[i]), 32'(exp_rd));
                    req[i][r] = 1'b0;
                end
            end
        end
        chk("ack_cycle", 0, 32'(ackat[0]), 32'(exp_ack0));
        chk("ack_cycle", 1, 32'(ackat[1]), 32'(exp_ack1));
        for (int i = 0; i < 2; i++) begin
            chk("mem_en_count", i, 32'(nen[i]),   32'd1);
            chk("busy_cycles",  i, 32'(nbusy[i]), 32'((i == 0) ? exp_ack0 : exp_ack1));
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int ng [2];
        int nack [2];
        int first_ack [2];
        int second_ack [2];
        int en2 [2];
        int nen [2];
        int a0 [2];
        int a1 [2];
        int seen [2];
        int rst_cnt;

        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 2; r++) set_req(i, r, 1'b0, 1'b0, 16'h0, 16'h0);
            for (int a = 0; a < 256; a++) begin
                dmem[i][a] <= 16'(a * 257) ^ 16'h5A5A;
                rmem[i][a] <= 16'(a * 257) ^ 16'h5A5A;
            end
            dmem[i][16] <= 16'hBEEF;  rmem[i][16] <= 16'hBEEF;
            dmem[i][4]  <= 16'h1234;  rmem[i][4]  <= 16'h1234;
            for (int k = 0; k < 4; k++) pipe[i][k] <= 16'h0;
        end

        // Reset state
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy",   i, 32'(busy[i]),     32'd0);
            chk("rst_gnt",    i, 32'(gnt[i]),      32'd0);
            chk("rst_rdata",  i, 32'(rdata[i]),    32'd0);
            chk("rst_maddr",  i, 32'(mem_addr[i]), 32'd0);
        end
        #2 reset = 1'b1;

        // Read 0x0010 via fetch port; write 0xA5A5 to 0x00FF via data port
        single(0, 1'b0, 16'h0010, 16'h0000, 3, 5, 16'hBEEF);
        single(1, 1'b1, 16'h00FF, 16'hA5A5, 2, 2, 16'hBEEF);
        for (int i = 0; i < 2; i++) chk("mem_written", i, 32'(dmem[i][255]), 32'hA5A5);
        single(0, 1'b0, 16'h00FF, 16'h0000, 3, 5, 16'hA5A5);
        single(0, 1'b0, 16'h0004, 16'h0000, 3, 5, 16'h1234);

        // Fairness from reset with both requesters held
        reset_pulse();
        for (int i = 0; i < 2; i++) begin
            ng[i] = 0;
            set_req(i, 0, 1'b1, 1'b0, 16'h0001, 16'h0);
            set_req(i, 1, 1'b1, 1'b0, 16'h0002, 16'h0);
        end
        for (int c = 0; c < 60; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (mem_en[i] && ng[i] < 4) begin
                    chk("fair_gnt",  i, 32'(gnt[i]),      32'(ng[i] % 2));
                    chk("fair_addr", i, 32'(mem_addr[i]), (ng[i] % 2 == 1) ? 32'h2 : 32'h1);
                    ng[i]++;
                end
                if (ng[i] >= 4) begin
                    if (ack[i][0]) req[i][0] = 1'b0;
                    if (ack[i][1]) req[i][1] = 1'b0;
                end
            end
        end
        for (int i = 0; i < 2; i++) chk("fair_grants", i, 32'(ng[i]), 32'd4);

        // Back-to-back transactions from a requester that keeps req high
        for (int i = 0; i < 2; i++) begin
            nack[i] = 0; first_ack[i] = 0; second_ack[i] = 0; en2[i] = 0; nen[i] = 0;
            set_req(i, 0, 1'b1, 1'b0, 16'h0010, 16'h0);
        end
        for (int c = 1; c <= 30; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (mem_en[i]) begin
                    nen[i]++;
                    if (nen[i] == 2) en2[i] = c;
                end
                if (ack[i][0]) begin
                    nack[i]++;
                    if (nack[i] == 1) first_ack[i] = c;
                    else begin
                        second_ack[i] = c;
                        req[i][0] = 1'b0;
                    end
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk("b2b_acks",    i, 32'(nack[i]), 32'd2);
            chk("b2b_reissue", i, 32'(en2[i] - first_ack[i]), 32'd2);
            chk("b2b_period",  i, 32'(second_ack[i] - first_ack[i]), (i == 0) ? 32'd4 : 32'd6);
        end

        // Asynchronous reset while the latency-3 instance is in WAIT
        for (int i = 0; i < 2; i++) set_req(i, 0, 1'b1, 1'b0, 16'h0004, 16'h0);
        tick();
        tick();
        tick();
        for (int i = 0; i < 2; i++) set_req(i, 1, 1'b1, 1'b0, 16'h0002, 16'h0);
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("arst_busy",   i, 32'(busy[i]),   32'd0);
            chk("arst_mem_en", i, 32'(mem_en[i]), 32'd0);
            chk("arst_ack0",   i, 32'(ack[i][0]), 32'd0);
            chk("arst_ack1",   i, 32'(ack[i][1]), 32'd0);
        end
        tick();
        #2 reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a0[i] = 0; a1[i] = 0; seen[i] = 0;
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (mem_en[i] && seen[i] == 0) begin
                    seen[i] = 1;
                    chk("arst_tie_gnt",  i, 32'(gnt[i]),      32'd0);
                    chk("arst_tie_addr", i, 32'(mem_addr[i]), 32'h4);
                end
                if (ack[i][0]) begin a0[i]++; req[i][0] = 1'b0; end
                if (ack[i][1]) begin a1[i]++; req[i][1] = 1'b0; end
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk("arst_acks0", i, 32'(a0[i]), 32'd1);
            chk("arst_acks1", i, 32'(a1[i]), 32'd1);
        end

        // Randomized traffic with occasional mid-cycle resets
        rst_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                for (int r = 0; r < 2; r++) begin
                    if (req[i][r]) begin
                        if (ack[i][r]) begin
                            if ($urandom_range(0, 1) == 0) req[i][r] = 1'b0;
                            else set_req(i, r, 1'b1, 1'($urandom_range(0, 1)),
                                         16'($urandom_range(0, 255)), 16'($urandom));
                        end
                    end else if ($urandom_range(0, 2) == 0) begin
                        set_req(i, r, 1'b1, 1'($urandom_range(0, 1)),
                                16'($urandom_range(0, 255)), 16'($urandom));
                    end
                end
            end
            if (reset && $urandom_range(0, 399) == 0) begin
                #2 reset = 1'b0;
                rst_cnt = $urandom_range(1, 2);
            end else if (!reset) begin
                rst_cnt--;
                if (rst_cnt <= 0) #2 reset = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
